// File: rtl/sram_image_writer.sv
// sram_image_writer: packs a 24-bit RGB raster stream into 16-bit SRAM words,
// three words per pixel pair, one full frame per start pulse.
module sram_image_writer #(
  parameter int AW           = 20,
  parameter int DW           = 16,
  parameter int START_ADDR   = 0,
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  input  logic          pix_valid,
  output logic          pix_ready,
  input  logic [7:0]    r,
  input  logic [7:0]    g,
  input  logic [7:0]    b,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          wr_enable
);

  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CW   = $clog2(NPIX + 1);
  localparam logic [AW-1:0] BASE = AW'(START_ADDR);
  localparam logic [CW-1:0] LAST = CW'(NPIX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVEN,
    S_ODD,
    S_FLUSH
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    ab_q, ab_d;
  logic [15:0]   bw_q, bw_d;
  logic          we_d;
  logic          done_d;
  logic [AW-1:0] waddr_d;
  logic [DW-1:0] wdata_d;
  logic          hs;
  logic          unused_rdata;

  assign raddr        = '0;
  assign unused_rdata = ^rdata;

  // Ready never looks at pix_valid; start masks it so an abort never writes.
  assign pix_ready = ((state_q == S_EVEN) || (state_q == S_ODD)) && !start;
  assign hs        = pix_valid && pix_ready;
  assign busy      = (state_q != S_IDLE) || done;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ab_d    = ab_q;
    bw_d    = bw_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    waddr_d = waddr;
    wdata_d = wdata;
    if (start) begin
      state_d = S_EVEN;
      addr_d  = BASE;
      cnt_d   = '0;
      ab_d    = '0;
      bw_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_EVEN: begin
          if (hs) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = DW'({g, r});
            ab_d    = b;
            addr_d  = addr_q + AW'(1);
            cnt_d   = cnt_q + CW'(1);
            state_d = S_ODD;
          end
        end
        S_ODD: begin
          if (hs) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = DW'({r, ab_q});
            bw_d    = {b, g};
            addr_d  = addr_q + AW'(1);
            cnt_d   = cnt_q + CW'(1);
            state_d = S_FLUSH;
          end
        end
        S_FLUSH: begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = DW'(bw_q);
          addr_d  = addr_q + AW'(1);
          if (cnt_q == LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_EVEN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      ab_q      <= '0;
      bw_q      <= '0;
      wr_enable <= 1'b0;
      done      <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      ab_q      <= ab_d;
      bw_q      <= bw_d;
      wr_enable <= we_d;
      done      <= done_d;
      waddr     <= waddr_d;
      wdata     <= wdata_d;
    end
  end

endmodule

// File: doc/sram_image_writer.md
# sram_image_writer

Packs a raster stream of 24-bit RGB pixels into 16-bit SRAM words and writes one full image frame starting at `START_ADDR`. It sits between the decompressor output and the SRAM write port. It produces the exact memory layout that the SRAM-to-VGA display path reads back: 3 words per 2 pixels, `W*H*3/2` words per frame.

## Interface
Parameters:
- `AW`, 20, SRAM address width
- `DW`, 16, SRAM data width (fixed at 16 for this packing)
- `START_ADDR`, 0, word address of pixel 0
- `IMAGE_WIDTH`, 320, pixels per line (`W`)
- `IMAGE_HEIGHT`, 240, lines per frame (`H`); `W*H` must be even

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  sole clock, rising edge
  - `reset`  in  1  asynchronous, active-low (0 = reset)
- Control:
  - `start`  in  1  one-cycle pulse; begins (or restarts) a frame
  - `busy`  out  1  high from the cycle after `start` until `done`
  - `done`  out  1  one-cycle pulse on the final write of the frame
- Pixel input:
  - `pix_valid`  in  1  pixel on `r/g/b` is valid
  - `pix_ready`  out  1  block can accept a pixel this cycle
  - `r`, `g`, `b`  in  8 each  pixel colour
- SRAM read port (unused):
  - `raddr`  out  AW  tied 0
  - `rdata`  in  DW  ignored
- SRAM write port:
  - `waddr`  out  AW  registered write address
  - `wdata`  out  DW  registered write data
  - `wr_enable`  out  1  registered write strobe, one word per cycle

## Operation
- Pixel word `P = {b,g,r}`: r in bits 7:0, g in 15:8, b in 23:16.
- Pixel pair layout (pixel 2k = A, pixel 2k+1 = B; base address `a = START_ADDR + 3k`):
  - `a` ← `{A.g, A.r}`
  - `a+1` ← `{B.r, A.b}`
  - `a+2` ← `{B.b, B.g}`
- Registers:
  - word address counter (AW bits)
  - pixel counter (`$clog2(W*H+1)` bits)
  - 8-bit held `A.b`
- States:
  - IDLE: `pix_ready=0`; `start` → EVEN, address ← `START_ADDR`, pixel count ← 0.
  - EVEN: `pix_ready=1`; on handshake (`pix_valid & pix_ready`), write word `a`, hold `A.b` → ODD.
  - ODD: `pix_ready=1`; on handshake, write word `a+1` → FLUSH.
  - FLUSH: `pix_ready=0`; write word `a+2`.
    - If the pixel count has reached `W*H`, pulse `done` → IDLE.
    - Otherwise → EVEN.
- The address counter increments by 1 on every write.
- The pixel counter increments on every handshake.
- With `pix_valid` held at 1, throughput is 2 pixels per 3 cycles.
- `pix_valid` low in EVEN/ODD: hold state, no write, held byte retained.
- `start` in any non-IDLE state aborts the frame:
  - address and pixel count are reset, held byte is discarded → EVEN;
  - no write occurs in that cycle, even if a handshake is present, and `pix_ready` is forced 0 while `start=1`.
- `pix_valid` in IDLE is ignored, and no writes occur.
- Address arithmetic wraps modulo `2^AW`; no range checking is done.

## Timing
- Reset values:
  - state IDLE;
  - `busy=0`, `done=0`, `wr_enable=0`, `waddr=0`, `wdata=0`, `pix_ready=0`;
  - counters 0, held byte 0.
- `pix_ready` is combinational from state and `start` only; it never depends on `pix_valid`.
- Write latency: a handshake at edge N drives `wr_enable/waddr/wdata` during cycle N+1 (registered).
- FLUSH write appears the cycle after the ODD write, so the three writes of a pair are back-to-back when input is continuous.
- `done` is high in the same cycle as the final `wr_enable` (word `START_ADDR + W*H*3/2 - 1`); `busy` falls in the following cycle.
- `wr_enable` is 0 in every cycle without a scheduled write.
- Asynchronous reset mid-frame: all outputs return to their reset values immediately; the partial frame is abandoned.

## Test plan
- Single pair, `W=2, H=1, START_ADDR=0x100`:
  - stimulus: `start`, then pixels `{r,g,b}={11,22,33}` and `{44,55,66}` with `pix_valid` continuous;
  - required: writes `0x100←0x2211`, `0x101←0x4433`, `0x102←0x6655` on consecutive cycles, `done` with the third write, `pix_ready=0` during FLUSH.
- Full frame, `W=4, H=2`, pixel i = `{i, i+0x40, i+0x80}`:
  - required: exactly 12 writes at addresses 0..11 with the packed values, a single `done` pulse, no writes afterwards.
- Backpressure, random `pix_valid` gaps (~50%):
  - required: SRAM image identical to the continuous case, no write in idle gaps, held `A.b` preserved across gaps.
- Restart, `start` pulsed after 3 pixels of a 4x2 frame:
  - required: no write in the `start` cycle, addressing restarts at `START_ADDR`, the final image reflects only post-restart pixels, one `done`.
- Reset, `reset` asserted low mid-ODD:
  - required: `wr_enable`, `busy`, `done`, and `pix_ready` go 0 without waiting for a clock edge; after release the state is IDLE and a new `start` writes from `START_ADDR`.
- Wrap, `AW=4, START_ADDR=14, W=2, H=1`:
  - required: writes to addresses 14, 15, 0.
